// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: priority stall vector, exception flush and held redirect.
// Optional STALL_PERF_EN adds saturating stall-cycle and flush counters.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        if_ready,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        redirect_valid
`ifdef STALL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  localparam logic [31:0] EXC_ERET   = 32'h0000_000e;
  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

  typedef enum logic {RUN, REDIRECT} state_t;

  state_t      state_q, state_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [5:0]  req_vec;

  // The deepest requesting stage freezes itself and everything upstream of it.
  always_comb begin
    req_vec = 6'b000000;
    if (stallreq_mem)     req_vec = 6'b011111;
    else if (stallreq_ex) req_vec = 6'b001111;
    else if (stallreq_id) req_vec = 6'b000111;
    else if (stallreq_if) req_vec = 6'b000011;
  end

  always_comb begin
    state_d        = state_q;
    new_pc_d       = new_pc_q;
    stall          = 6'b000000;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    // Outputs are gated by rst so they drop the moment reset asserts.
    if (rst) begin
      case (state_q)
        RUN: begin
          if (excepttype_i != 32'h0) begin
            flush    = 1'b1;
            new_pc_d = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
            state_d  = REDIRECT;
          end else begin
            stall = req_vec;
          end
        end
        REDIRECT: begin
          redirect_valid = 1'b1;
          stall          = 6'b000011 | req_vec;
          if (if_ready) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      new_pc_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      new_pc_q <= new_pc_d;
    end
  end

  assign new_pc = new_pc_q;

`ifdef STALL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (stall[0] && (stall_cycles_q != 32'hFFFF_FFFF)) stall_cycles_d = stall_cycles_q + 32'd1;
    if (flush && (flush_count_q != 16'hFFFF))         flush_count_d  = flush_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= 32'h0;
      flush_count_q  <= 16'h0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule
